pulse_gen: RTL and testbench
============================

# pulse_gen

Edge-to-pulse converter for the `pulse` block (port names follow the codebase). It takes an asynchronous level input `a`, synchronizes it into the `clk` domain, detects the selected edge, and drives a clean, registered pulse on `x` of programmable length. It sits at the boundary between external or asynchronous control signals and synchronous logic that needs one-shot events.

## Interface

One clock; reset is synchronous and active-high.

Parameters:
- `SYNC_STAGES`, default 2: number of synchronizer flops on `a`. Legal range 2–4.
- `EDGE_MODE`, default 0: selects which edges trigger a pulse.
  - 0 = rising edges.
  - 1 = falling edges.
  - 2 = both edges.
- `PULSE_LEN`, default 1: width of the output pulse in `clk` cycles. Legal range 1–255.

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `a`, input, 1: asynchronous level input. May change at any time.
- `x`, output, 1: registered pulse output.

## Operation

- **Synchronizer:** a chain of `SYNC_STAGES` flops samples `a`. Its last stage is `s`.
- **Edge detection:** a register `p` holds the previous value of `s`. A qualifying edge is:
  - rising: `s & ~p`;
  - falling: `~s & p`;
  - both: `s ^ p`.
- **Pulse counter:** width `$clog2(PULSE_LEN+1)`.
  - A qualifying edge loads the counter with `PULSE_LEN`.
  - Otherwise, a nonzero counter decrements by 1 each cycle.
  - `x` is registered as "counter will be nonzero next cycle".
- **Retrigger:** a qualifying edge while `x` is high reloads the counter to `PULSE_LEN`. `x` stays high continuously with no gap, and the pulse ends `PULSE_LEN` cycles after the last edge.
- **Reset (`rst`=1 at a clock edge):**
  - synchronizer flops, `p` and counter are cleared to 0;
  - `x` = 0 in the cycle after that edge.
  - Reset mid-pulse terminates the pulse immediately.
  - If `a` is high when reset releases, the synchronizer fills with 1 and one rising-edge pulse is generated. This is defined behaviour.
- **Input-width limits:**
  - A level on `a` shorter than one `clk` period may be missed entirely. This is permitted, but it must never produce a partial-width pulse.
  - A level stable across ≥2 `clk` rising edges must be detected.
- **Event counting:** each qualifying transition of `s` produces exactly one pulse-start event. No events are generated while `rst`=1.

## Timing

- Let `a` change before clock edge k and be captured by synchronizer stage 1 at edge k. With `PULSE_DEGLITCH_EN` off:
  - `s` reflects the change after edge k+`SYNC_STAGES`−1;
  - `x` rises after edge k+`SYNC_STAGES`;
  - `x` falls after edge k+`SYNC_STAGES`+`PULSE_LEN`.
- Default latency is therefore 2 cycles from capture to `x` high, with a 1-cycle pulse.
- `x` is a flop output: glitch-free and with no combinational path from `a`.
- Back-to-back qualifying edges on consecutive cycles (`EDGE_MODE`=2, `a` toggling every cycle) hold `x` high continuously.

## Configuration

- Macro: `PULSE_DEGLITCH_EN`.
- **When defined:**
  - A filter stage sits between `s` and the edge detector.
  - The filtered level takes a new value only after `s` has held that value on 2 consecutive clock edges.
  - Any level on `s` lasting exactly 1 cycle is ignored.
  - Latency increases by 1 cycle.
  - The filter register resets to 0.
- **When undefined:** `s` feeds the edge detector directly, with no added latency.

## Test plan

- **Reset:** hold `rst`=1 for 3 cycles while toggling `a` → `x`=0 throughout. After release with `a`=0, `x` stays 0.
- **Basic rising edge (defaults):** `a` 0→1 captured at edge k → `x`=1 exactly during the cycle after edge k+2, then 0. `a` 1→0 produces no pulse.
- **Both edges with stretch:** `EDGE_MODE`=2, `PULSE_LEN`=4; toggle `a` every 20 cycles → one 4-cycle pulse per toggle, each starting 2 cycles after capture. Expect 25 toggles → 25 pulses.
- **Retrigger:** `PULSE_LEN`=8; rising edges captured 3 cycles apart → `x` high continuously from the first pulse start until 8 cycles after the second.
- **Random async stimulus:** `clk` period 10 ns; `a` toggles at random intervals of 10–42 ns, 25 toggles, `EDGE_MODE`=2 → pulse count equals the number of `s` transitions. Every pulse is exactly `PULSE_LEN` cycles unless retriggered.
- **Deglitch and mid-pulse reset:**
  - With `PULSE_DEGLITCH_EN`: a 1-cycle high on `a` → no pulse; a 3-cycle high → one pulse at latency 3.
  - Assert `rst` during a `PULSE_LEN`=8 pulse → `x`=0 the next cycle.

Source files
------------

// File: rtl/pulse_gen.sv
`timescale 1ns/1ps
// pulse_gen: synchronizes async level `a`, detects the selected edge and drives a
// registered PULSE_LEN-cycle pulse on `x`. Optional macro PULSE_DEGLITCH_EN adds a level filter.
module pulse_gen #(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 0,
   parameter int PULSE_LEN   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   output logic x
);

   localparam int CW = $clog2(PULSE_LEN + 1);
   localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_BOTH = 2'd2
   } edge_mode_e;

   localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   d;
   logic                   p;
   logic                   hit;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_next;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], a};
   end

   assign s = sync[SYNC_STAGES-1];

`ifdef PULSE_DEGLITCH_EN
   logic f;

   // The stage feeding s already holds s's next value: equality means s keeps its level over two edges.
   always_ff @(posedge clk) begin
      if (rst)                            f <= 1'b0;
      else if (sync[SYNC_STAGES-2] == s)  f <= s;
   end

   assign d = f;
`else
   assign d = s;
`endif

   always_ff @(posedge clk) begin
      if (rst) p <= 1'b0;
      else     p <= d;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      hit      = 1'b0;
      cnt_next = cnt;
      case (MODE)
         EDGE_RISE: hit = d & ~p;
         EDGE_FALL: hit = ~d & p;
         EDGE_BOTH: hit = d ^ p;
         default:   hit = 1'b0;
      endcase
      if (hit)              cnt_next = LOAD;
      else if (cnt != '0)   cnt_next = cnt - CW'(1);
   end

   // x is the registered "counter nonzero" flag, so it never glitches and retriggers leave no gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         x   <= 1'b0;
      end else begin
         cnt <= cnt_next;
         x   <= (cnt_next != '0);
      end
   end

endmodule

// File: tb/tb_pulse_gen.sv
`timescale 1ns/1ps
// tb_pulse_gen: four pulse_gen configurations share one async input; each is compared every
// cycle against an edge-indexed history model, plus directed latency/count/retrigger/reset checks.
module tb_pulse_gen;

   localparam int NI   = 4;
   localparam int MAXN = 2048;
   localparam int CFG_S [NI] = '{2, 2, 3, 4};
   localparam int CFG_E [NI] = '{0, 2, 0, 1};
   localparam int CFG_L [NI] = '{1, 4, 8, 3};
`ifdef PULSE_DEGLITCH_EN
   localparam int DG = 1;
`else
   localparam int DG = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a   = 1'b0;
   logic [NI-1:0] x_v;

   pulse_gen #(.SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_LEN(1)) u0 (.clk(clk), .rst(rst), .a(a), .x(x_v[0]));
   pulse_gen #(.SYNC_STAGES(2), .EDGE_MODE(2), .PULSE_LEN(4)) u1 (.clk(clk), .rst(rst), .a(a), .x(x_v[1]));
   pulse_gen #(.SYNC_STAGES(3), .EDGE_MODE(0), .PULSE_LEN(8)) u2 (.clk(clk), .rst(rst), .a(a), .x(x_v[2]));
   pulse_gen #(.SYNC_STAGES(4), .EDGE_MODE(1), .PULSE_LEN(3)) u3 (.clk(clk), .rst(rst), .a(a), .x(x_v[3]));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: per-edge histories of what stage 1 saw and of rst.
   int  n        = 0;
   int  last_rst = -100000;
   int  last_ev [NI];
   bit  exp_x   [NI];
   bit  ah [MAXN];
   bit  rh [MAXN];
   bit  sv [NI][MAXN];
   bit  dv [NI][MAXN];
   int  m_s;
   bit  m_sn, m_f, m_cur, m_prv, m_ev;

   always @(posedge clk) begin
      if (n < MAXN) begin
         ah[n] = a;
         rh[n] = rst;
         if (rst) last_rst = n;
         for (int i = 0; i < NI; i++) begin
            m_s  = CFG_S[i];
            // s after edge n is the value captured S-1 edges earlier, unless a reset intervened.
            m_sn = (n - m_s + 1 >= 0 && last_rst < n - m_s + 1) ? ah[n - m_s + 1] : 1'b0;
            sv[i][n] = m_sn;
            if (DG != 0) begin
               if (rst)                           m_f = 1'b0;
               else if (n > 0 && m_sn == sv[i][n-1]) m_f = m_sn;
               else                               m_f = (n > 0) ? dv[i][n-1] : 1'b0;
            end else begin
               m_f = m_sn;
            end
            dv[i][n] = m_f;
            m_ev = 1'b0;
            if (!rst && n >= 2) begin
               m_cur = dv[i][n-1];
               m_prv = rh[n-1] ? 1'b0 : dv[i][n-2];
               case (CFG_E[i])
                  0:       m_ev = m_cur & ~m_prv;
                  1:       m_ev = ~m_cur & m_prv;
                  default: m_ev = m_cur ^ m_prv;
               endcase
            end
            if (rst)       last_ev[i] = -100000;
            else if (m_ev) last_ev[i] = n;
            exp_x[i] = (n - last_ev[i]) < CFG_L[i];
         end
         n++;
      end
   end

   bit cnt1_en = 1'b0;
   bit cnt2_en = 1'b0;
   bit x1_prev = 1'b0;
   int rise1   = 0;
   int high2   = 0;

   always @(negedge clk) begin
      if (n > 0 && n < MAXN) begin
         for (int i = 0; i < NI; i++)
            check($sformatf("model_x%0d", i), 32'(x_v[i]), 32'(exp_x[i]));
      end
      if (cnt1_en && x_v[1] && !x1_prev) rise1++;
      if (cnt2_en && x_v[2]) high2++;
      x1_prev = x_v[1];
   end

   task automatic wait_cyc(input int k);
      repeat (k) @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int lat;
   int d;
   bit seen;

   initial begin
      for (int i = 0; i < NI; i++) last_ev[i] = -100000;
      lat = 2 + DG;

      // Reset held with a toggling.
      wait_cyc(1);
      repeat (3) begin
         a = ~a;
         wait_cyc(1);
      end
      check("reset_x", 32'(x_v), 32'(0));
      a = 1'b0;
      wait_cyc(1);
      rst = 1'b0;
      wait_cyc(10);
      check("post_reset_x", 32'(x_v), 32'(0));

      // Basic rising edge latency on the default configuration.
      a = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check("basic_rise", 32'(x_v[0]), 32'(j == lat));
      end
      #1 a = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("basic_fall", 32'(x_v[0]), 32'(0));
      end
      wait_cyc(10);

      // Both edges, PULSE_LEN 4: 25 toggles 20 cycles apart.
      cnt1_en = 1'b1;
      repeat (25) begin
         a = ~a;
         wait_cyc(20);
      end
      cnt1_en = 1'b0;
      check("both_pulse_count", 32'(rise1), 32'(25));

      // Retrigger, PULSE_LEN 8: rising edges captured 3 cycles apart.
      a = 1'b0;
      wait_cyc(12);
      cnt2_en = 1'b1;
      a = 1'b1;
      wait_cyc(1);
      a = 1'b0;
      wait_cyc(2);
      a = 1'b1;
      wait_cyc(25);
      cnt2_en = 1'b0;
      check("retrigger_len", 32'(high2), 32'((DG != 0) ? 8 : 11));

      // Reset in the middle of a PULSE_LEN 8 pulse.
      a = 1'b0;
      wait_cyc(12);
      a = 1'b1;
      seen = 1'b0;
      for (int j = 0; j < 30 && !seen; j++) begin
         @(negedge clk);
         seen = x_v[2];
      end
      check("midrst_pulse_seen", 32'(seen), 32'(1));
      @(negedge clk);
      @(negedge clk);
      check("midrst_before", 32'(x_v[2]), 32'(1));
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_after", 32'(x_v[2]), 32'(0));
      #1 rst = 1'b0;
      wait_cyc(15);

      // Random asynchronous toggles, 10-42 ns apart, never on a rising clock edge.
      repeat (25) begin
         d = int'($urandom_range(42, 10));
         if ((($time + d) % 10) == 5) d++;
         #d a = ~a;
      end
      wait_cyc(20);

      // Short highs: one cycle (filtered when deglitch is on) then three cycles.
      a = 1'b0;
      wait_cyc(12);
      a = 1'b1;
      wait_cyc(1);
      a = 1'b0;
      wait_cyc(12);
      a = 1'b1;
      wait_cyc(3);
      a = 1'b0;
      wait_cyc(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
